// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared types and constants for the writeback port arbiter
package wb_port_arbiter_pkg;

    localparam int DEF_BITS_SIZE = 32;
    localparam int DEF_BITS_REGS = 5;
    localparam int REG_ZERO      = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PENDING = 2'b01,
        ST_FORCE   = 2'b10
    } arb_state_e;

endpackage

// File: rtl/wb_hold_buffer.sv
// rtl/wb_hold_buffer.sv - one-entry {valid,rd,data} holding register for a deferred long-unit result
module wb_hold_buffer
    import wb_port_arbiter_pkg::*;
#(
    parameter int BITS_SIZE = DEF_BITS_SIZE,
    parameter int BITS_REGS = DEF_BITS_REGS
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic                 i_clear,
    input  logic [BITS_REGS-1:0] i_rd,
    input  logic [BITS_SIZE-1:0] i_data,
    output logic                 o_valid,
    output logic [BITS_REGS-1:0] o_rd,
    output logic [BITS_SIZE-1:0] o_data
);

    logic                 valid_q;
    logic [BITS_REGS-1:0] rd_q;
    logic [BITS_SIZE-1:0] data_q;

    // Clear wins over load so a discarded entry can never reappear.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else if (i_load) begin
            valid_q <= 1'b1;
            rd_q    <= i_rd;
            data_q  <= i_data;
        end
    end

    assign o_valid = valid_q;
    assign o_rd    = rd_q;
    assign o_data  = data_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write port between pipeline writeback and a long-latency unit
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int BITS_SIZE = DEF_BITS_SIZE,
    parameter int BITS_REGS = DEF_BITS_REGS,
    parameter int MAX_WAIT  = 4,
    parameter int WAIT_BITS = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wb_reg_write,
    input  logic [BITS_REGS-1:0] i_wb_rd,
    input  logic [BITS_SIZE-1:0] i_wb_data,
    input  logic                 i_lu_valid,
    input  logic [BITS_REGS-1:0] i_lu_rd,
    input  logic [BITS_SIZE-1:0] i_lu_data,
    output logic                 o_lu_ready,
    output logic                 o_rf_we,
    output logic [BITS_REGS-1:0] o_rf_addr,
    output logic [BITS_SIZE-1:0] o_rf_data,
    output logic                 o_stall,
    output logic                 o_waw_drop,
    output logic                 o_busy
);

    arb_state_e           state_q, state_d;
    logic [WAIT_BITS-1:0] wait_q, wait_d;
    logic                 rf_we_q, rf_we_d;
    logic [BITS_REGS-1:0] rf_addr_q, rf_addr_d;
    logic [BITS_SIZE-1:0] rf_data_q, rf_data_d;
    logic                 waw_q, waw_d;

    logic                 buf_load, buf_clear, buf_valid;
    logic [BITS_REGS-1:0] buf_rd;
    logic [BITS_SIZE-1:0] buf_data;
    logic                 wb_eff, lu_eff;

    wb_hold_buffer #(
        .BITS_SIZE (BITS_SIZE),
        .BITS_REGS (BITS_REGS)
    ) u_hold (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (buf_load),
        .i_clear (buf_clear),
        .i_rd    (i_lu_rd),
        .i_data  (i_lu_data),
        .o_valid (buf_valid),
        .o_rd    (buf_rd),
        .o_data  (buf_data)
    );

    assign wb_eff = i_wb_reg_write && (i_wb_rd != BITS_REGS'(REG_ZERO));
    assign lu_eff = i_lu_valid && (i_lu_rd != BITS_REGS'(REG_ZERO));

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        waw_d     = 1'b0;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb_eff) begin
                    rf_we_d   = 1'b1;
                    rf_addr_d = i_wb_rd;
                    rf_data_d = i_wb_data;
                    // Same-cycle long-unit result to the same rd is the older write: drop it.
                    if (lu_eff && (i_lu_rd == i_wb_rd)) begin
                        waw_d = 1'b1;
                    end else if (lu_eff) begin
                        buf_load = 1'b1;
                        wait_d   = '0;
                        state_d  = ST_PENDING;
                    end
                end else if (lu_eff) begin
                    rf_we_d   = 1'b1;
                    rf_addr_d = i_lu_rd;
                    rf_data_d = i_lu_data;
                end
            end
            ST_PENDING: begin
                if (!wb_eff) begin
                    rf_we_d   = buf_valid;
                    rf_addr_d = buf_rd;
                    rf_data_d = buf_data;
                    buf_clear = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    rf_we_d   = 1'b1;
                    rf_addr_d = i_wb_rd;
                    rf_data_d = i_wb_data;
                    if (i_wb_rd == buf_rd) begin
                        waw_d     = 1'b1;
                        buf_clear = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        wait_d = wait_q + 1'b1;
                        if ((int'(wait_q) + 1) >= (MAX_WAIT - 1)) begin
                            state_d = ST_FORCE;
                        end
                    end
                end
            end
            ST_FORCE: begin
                rf_we_d   = buf_valid;
                rf_addr_d = buf_rd;
                rf_data_d = buf_data;
                buf_clear = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                buf_clear = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            waw_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            waw_q     <= waw_d;
        end
    end

    assign o_lu_ready = (state_q == ST_IDLE);
    assign o_stall    = (state_q == ST_FORCE);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_rf_we    = rf_we_q;
    assign o_rf_addr  = rf_addr_q;
    assign o_rf_data  = rf_data_q;
    assign o_waw_drop = waw_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for the writeback port arbiter
module tb_wb_port_arbiter;

    logic        i_clk;
    logic        i_reset;
    logic        i_wb_reg_write;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic        i_lu_valid;
    logic [4:0]  i_lu_rd;
    logic [31:0] i_lu_data;
    logic        o_lu_ready;
    logic        o_rf_we;
    logic [4:0]  o_rf_addr;
    logic [31:0] o_rf_data;
    logic        o_stall;
    logic        o_waw_drop;
    logic        o_busy;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_total  = 0;
    int  n_passed = 0;
    int  stall_cnt = 0;
    int  waw_cnt   = 0;

    wb_port_arbiter #(
        .BITS_SIZE (32),
        .BITS_REGS (5),
        .MAX_WAIT  (4),
        .WAIT_BITS (3)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_wb_reg_write (i_wb_reg_write),
        .i_wb_rd        (i_wb_rd),
        .i_wb_data      (i_wb_data),
        .i_lu_valid     (i_lu_valid),
        .i_lu_rd        (i_lu_rd),
        .i_lu_data      (i_lu_data),
        .o_lu_ready     (o_lu_ready),
        .o_rf_we        (o_rf_we),
        .o_rf_addr      (o_rf_addr),
        .o_rf_data      (o_rf_data),
        .o_stall        (o_stall),
        .o_waw_drop     (o_waw_drop),
        .o_busy         (o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic cyc(input logic wwe, input logic [4:0] wrd, input logic [31:0] wdat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        i_wb_reg_write = wwe;
        i_wb_rd        = wrd;
        i_wb_data      = wdat;
        i_lu_valid     = lv;
        i_lu_rd        = lrd;
        i_lu_data      = ldat;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Write-port monitor: every write must match the head of the expected queue.
    always @(negedge i_clk) begin
        if (o_stall) stall_cnt++;
        if (o_waw_drop) waw_cnt++;
        if (o_rf_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, o_rf_addr, o_rf_data}, 64'd0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", 64'(o_rf_addr), 64'(w.addr));
                check("wr_data", 64'(o_rf_data), 64'(w.data));
            end
        end
    end

    initial begin
        i_reset = 1'b1;
        idle();
        idle();
        i_reset = 1'b0;
        check("rst_we",    64'(o_rf_we), 64'd0);
        check("rst_addr",  64'(o_rf_addr), 64'd0);
        check("rst_data",  64'(o_rf_data), 64'd0);
        check("rst_waw",   64'(o_waw_drop), 64'd0);
        check("rst_busy",  64'(o_busy), 64'd0);
        check("rst_stall", 64'(o_stall), 64'd0);
        check("rst_ready", 64'(o_lu_ready), 64'd1);

        // Reset mid-PENDING drops buffered rd 5
        expect_wr(5'd2, 32'h0000_0002);
        cyc(1'b1, 5'd2, 32'h0000_0002, 1'b1, 5'd5, 32'h0000_0005);
        check("t1_busy_pend", 64'(o_busy), 64'd1);
        i_reset = 1'b1;
        idle();
        i_reset = 1'b0;
        check("t1_busy_rst", 64'(o_busy), 64'd0);
        check("t1_we_rst",   64'(o_rf_we), 64'd0);
        idle();
        idle();
        check("t1_q_empty", 64'(exp_q.size()), 64'd0);

        // Direct long-unit write
        expect_wr(5'd3, 32'hDEAD_BEEF);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hDEAD_BEEF);
        check("t2_we",    64'(o_rf_we), 64'd1);
        check("t2_ready", 64'(o_lu_ready), 64'd1);
        check("t2_busy",  64'(o_busy), 64'd0);

        // Collision: pipeline first, buffered result next cycle
        expect_wr(5'd4, 32'h22);
        expect_wr(5'd3, 32'h11);
        cyc(1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11);
        check("t3_busy",  64'(o_busy), 64'd1);
        check("t3_ready", 64'(o_lu_ready), 64'd0);
        idle();
        check("t3_busy_done", 64'(o_busy), 64'd0);
        check("t3_we2",       64'(o_rf_we), 64'd1);
        idle();
        check("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // Starvation forces a slot; stalled rd11 is re-presented afterwards
        stall_cnt = 0;
        expect_wr(5'd6, 32'h60);
        expect_wr(5'd8, 32'h80);
        expect_wr(5'd9, 32'h90);
        expect_wr(5'd10, 32'hA0);
        expect_wr(5'd7, 32'h77);
        expect_wr(5'd11, 32'hB0);
        cyc(1'b1, 5'd6, 32'h60, 1'b1, 5'd7, 32'h77);
        cyc(1'b1, 5'd8, 32'h80, 1'b0, 5'd0, 32'd0);
        cyc(1'b1, 5'd9, 32'h90, 1'b0, 5'd0, 32'd0);
        check("t4_no_stall_yet", 64'(o_stall), 64'd0);
        cyc(1'b1, 5'd10, 32'hA0, 1'b0, 5'd0, 32'd0);
        check("t4_stall", 64'(o_stall), 64'd1);
        check("t4_busy",  64'(o_busy), 64'd1);
        cyc(1'b1, 5'd11, 32'hB0, 1'b1, 5'd12, 32'hC0);
        check("t4_stall_off", 64'(o_stall), 64'd0);
        check("t4_force_addr", 64'(o_rf_addr), 64'd7);
        cyc(1'b1, 5'd11, 32'hB0, 1'b0, 5'd0, 32'd0);
        idle();
        check("t4_stall_cnt", 64'(stall_cnt), 64'd1);
        check("t4_q_empty", 64'(exp_q.size()), 64'd0);

        // WAW against the buffer
        waw_cnt = 0;
        expect_wr(5'd2, 32'h20);
        expect_wr(5'd7, 32'h55);
        cyc(1'b1, 5'd2, 32'h20, 1'b1, 5'd7, 32'h70);
        cyc(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 32'd0);
        check("t5_waw",  64'(o_waw_drop), 64'd1);
        check("t5_busy", 64'(o_busy), 64'd0);
        idle();
        check("t5_waw_off", 64'(o_waw_drop), 64'd0);
        idle();
        check("t5_waw_cnt", 64'(waw_cnt), 64'd1);

        // Same-cycle WAW in IDLE
        expect_wr(5'd9, 32'h99);
        cyc(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h98);
        check("t5b_waw",  64'(o_waw_drop), 64'd1);
        check("t5b_busy", 64'(o_busy), 64'd0);
        idle();
        check("t5b_q_empty", 64'(exp_q.size()), 64'd0);

        // Register zero
        cyc(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5678);
        check("t6_we",   64'(o_rf_we), 64'd0);
        check("t6_busy", 64'(o_busy), 64'd0);
        check("t6_waw",  64'(o_waw_drop), 64'd0);
        expect_wr(5'd5, 32'h5A5A);
        cyc(1'b1, 5'd0, 32'h1234, 1'b1, 5'd5, 32'h5A5A);
        check("t6_lu_wins", 64'(o_rf_we), 64'd1);
        check("t6b_busy",   64'(o_busy), 64'd0);
        idle();
        idle();
        check("final_q_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the pipeline writeback path (the MEM/WB select result) and a multi-cycle long-latency unit (mult/div result). Pipeline writeback has priority; a long-unit result that cannot be written immediately goes into a one-entry holding buffer. If the buffer waits too long, the block forces a write slot by stalling the pipeline. It also resolves WAW conflicts between a buffered result and a newer pipeline write. It sits between the writeback data select and the register file write port.

Parameters:
BITS_SIZE, 32, data width.
BITS_REGS, 5, register address width.
MAX_WAIT, 4, cycles a buffered result may lose arbitration before a forced slot; must be >=1.
WAIT_BITS, 3, width of the wait counter; must satisfy 2**WAIT_BITS >= MAX_WAIT.

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_wb_reg_write  in  1  pipeline writeback write request
i_wb_rd  in  BITS_REGS  pipeline destination register
i_wb_data  in  BITS_SIZE  pipeline writeback data (the select-mux output)
i_lu_valid  in  1  long-unit result valid
i_lu_rd  in  BITS_REGS  long-unit destination register
i_lu_data  in  BITS_SIZE  long-unit result
o_lu_ready  out  1  arbiter can accept a long-unit result; transfer occurs when valid & ready
o_rf_we  out  1  register-file write enable (registered)
o_rf_addr  out  BITS_REGS  register-file write address (registered)
o_rf_data  out  BITS_SIZE  register-file write data (registered)
o_stall  out  1  pipeline freeze request (combinational from state)
o_waw_drop  out  1  one-cycle pulse: buffered result discarded due to WAW (registered)
o_busy  out  1  buffer occupied (state != IDLE)

Behaviour:
- Reset (sync, i_reset=1 at a clock edge):
  - o_rf_we=0, o_rf_addr=0, o_rf_data=0, o_waw_drop=0.
  - State goes to IDLE; buffer and wait counter are cleared.
  - Reset mid-operation discards any buffered result with no write.
- Write-port latency: one cycle. The winner selected in cycle N appears on o_rf_* in cycle N+1. o_rf_we=0 in any cycle with no winner.
- Register 0: any write with rd==0 is suppressed (o_rf_we stays 0). A long-unit result to rd 0 is accepted and discarded without entering the buffer.
- States: IDLE, PENDING, FORCE.
- IDLE:
  - o_lu_ready=1, o_stall=0.
  - If an effective pipeline write is present (i_wb_reg_write=1, i_wb_rd!=0), the pipeline wins.
  - If i_lu_valid and i_lu_rd!=0:
    - With no effective pipeline write, the long-unit result wins directly; stay in IDLE.
    - Otherwise capture {rd,data} in the buffer, clear the counter, go to PENDING.
  - Exception: if i_lu_rd equals an effective pipeline i_wb_rd in the same cycle, the long-unit result is treated as older. The pipeline write is performed, the long-unit result is discarded, o_waw_drop pulses, and the state stays IDLE.
- PENDING (o_lu_ready=0, o_stall=0; i_lu_valid is ignored):
  - Effective pipeline write with i_wb_rd==buf_rd: pipeline wins, buffer discarded, o_waw_drop pulses, go to IDLE.
  - No effective pipeline write: buffer wins, go to IDLE.
  - Otherwise: pipeline wins and the counter increments. When the counter reaches MAX_WAIT-1 in this cycle, go to FORCE.
- FORCE (o_stall=1, o_lu_ready=0):
  - Buffer wins unconditionally and the pipeline write inputs are ignored. The pipeline holds MEM/WB while stalled and re-presents the write next cycle.
  - No WAW drop in FORCE: the buffer is older and the held pipeline write lands afterwards, so ordering is correct.
  - Next state: IDLE.
- o_stall is high for exactly one cycle per forced slot. o_busy=1 in PENDING and FORCE.
- Per-cycle invariant: at most one write to the port per cycle; no write is lost except a WAW drop or a rd==0 write.

Decomposition:
- Shared package/header:
  - State encoding: IDLE=2'b00, PENDING=2'b01, FORCE=2'b10.
  - BITS_SIZE and BITS_REGS defaults.
  - REG_ZERO constant.
- Natural sub-module: wb_hold_buffer, a one-entry {valid,rd,data} register with load/clear. The FSM, counter and output registers stay in the top.

Test Plan:
1. Reset applied mid-PENDING (buffer rd=5) -> next cycle o_busy=0, o_rf_we=0, and rd 5 is never written.
2. IDLE, lu valid rd=3 data=0xDEADBEEF, no wb write -> next cycle o_rf_we=1, addr=3, data=0xDEADBEEF; o_lu_ready stays 1.
3. lu rd=3 data=0x11 and wb rd=4 data=0x22 in the same cycle, then no wb write -> writes rd4=0x22, then rd3=0x11 on consecutive cycles; o_busy=1 for one cycle.
4. Buffer rd=7 with wb writes to rd 8,9,10,11 back-to-back (MAX_WAIT=4) -> o_stall=1 in cycle 4, o_rf_* = rd7 the following cycle, then the held rd11 write the next cycle.
5. Buffer rd=7, then wb write rd=7 data=0x55 -> o_rf_* = rd7=0x55, o_waw_drop pulses once, the buffered value is never written, state returns to IDLE.
6. wb rd=0 with i_wb_reg_write=1, and lu rd=0 valid -> o_rf_we stays 0, state stays IDLE, o_waw_drop=0.
